pll_lock_mgr: RTL and testbench



---
 rtl/pll_lock_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_mgr.sv | 153 +++++++++++++++
 tb/tb_pll_lock_mgr.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL lock manager.
//   state_e   : supervisor FSM states, 3-bit encoding
//   cnt_width : width of the shared state counter, derived from the timing parameters
package pll_lock_pkg;

    typedef enum logic [2:0] {
        StPrst   = 3'd0,
        StWait   = 3'd1,
        StStable = 3'd2,
        StRun    = 3'd3,
        StLost   = 3'd4
    } state_e;

    // The counter only ever holds values 0 .. max-1, so clog2(max) bits suffice.
    // Clamp to 1 bit so a degenerate all-ones parameter set still gives a legal vector.
    function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles,
                                              input int unsigned loss_filter);
        int unsigned m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        if (loss_filter > m) m = loss_filter;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single-bit (or independent multi-bit) async inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both stages clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, two destination-clock cycles of latency
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL lock supervisor on the free-running board clock. Pulses the PLL reset, qualifies the
// asynchronous lock, and releases downstream reset only after lock has been stable.
//   clk        : free-running reference clock
//   rst_n      : asynchronous active-low reset
//   pll_lock   : PLL lock, asynchronous to clk
//   pll_rst    : active-high PLL reset, high only in StPrst
//   sys_rst_n  : active-low reset for PLL-clocked logic, high only in StRun
//   locked     : high only in StRun
//   relock_cnt : saturating count of qualified lock losses
// Build option: define PLL_LOCK_MGR_RELOCK_CNT_EN to build the relock counter; otherwise
// relock_cnt is tied to zero.
module pll_lock_mgr
    import pll_lock_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             locked,
    output logic [CNT_W-1:0] relock_cnt
);

    localparam int unsigned CntW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                             LOSS_FILTER);

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] LossLast    = CntW'(LOSS_FILTER - 1);

    logic            lock_s;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            pll_rst_q;
    logic            sys_rst_n_q;
    logic            locked_q;

    sync_2ff #(
        .Width (1)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    // Outputs are updated on the same edge as the state so they always match state_q.
    // The counter is cleared on every transition and reused by each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPrst;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                StPrst: begin
                    if (cnt_q == RstLast) begin
                        state_q   <= StWait;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWait: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (cnt_q == TimeoutLast) begin
                        state_q   <= StPrst;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStable: begin
                    if (!lock_s) begin
                        state_q <= StWait;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q     <= StRun;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b1;
                        locked_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    // cnt_q is the loss filter here: any high sample restarts it.
                    if (lock_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LossLast) begin
                        state_q     <= StLost;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b0;
                        locked_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StLost: begin
                    state_q   <= StPrst;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                end
                default: begin
                    state_q     <= StPrst;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_MGR_RELOCK_CNT_EN
    logic             lost_evt;
    logic [CNT_W-1:0] relock_q;

    // Same condition as the StRun -> StLost transition, so the count is visible in StLost.
    assign lost_evt = (state_q == StRun) && !lock_s && (cnt_q == LossLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= '0;
        end else if (lost_evt && (relock_q != '1)) begin
            relock_q <= relock_q + CNT_W'(1);
        end
    end

    assign relock_cnt = relock_q;
`else
    assign relock_cnt = '0;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Directed bench for pll_lock_mgr. u_dut uses the reference timing set; u_sat uses a
// shortened set so that several hundred lock losses fit in a short run.
module tb_pll_lock_mgr;

`ifdef PLL_LOCK_MGR_RELOCK_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       sat_lock;
    logic       pll_rst, sys_rst_n, locked;
    logic [7:0] relock_cnt;
    logic       sat_pll_rst, sat_sys_rst_n, sat_locked;
    logic [7:0] sat_relock;

    always #10 clk = ~clk;

    pll_lock_mgr #(
        .RST_CYCLES    (16),
        .LOCK_TIMEOUT  (1000),
        .STABLE_CYCLES (256),
        .LOSS_FILTER   (4),
        .CNT_W         (8)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .locked     (locked),
        .relock_cnt (relock_cnt)
    );

    pll_lock_mgr #(
        .RST_CYCLES    (2),
        .LOCK_TIMEOUT  (40),
        .STABLE_CYCLES (4),
        .LOSS_FILTER   (2),
        .CNT_W         (8)
    ) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (sat_lock),
        .pll_rst    (sat_pll_rst),
        .sys_rst_n  (sat_sys_rst_n),
        .locked     (sat_locked),
        .relock_cnt (sat_relock)
    );

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_t2 = 1'b0;
    int   t2_bad = 0;

    always @(negedge clk) begin
        if (mon_t2 && (sys_rst_n || locked)) t2_bad <= t2_bad + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int id);
        case (id)
            0:       return sys_rst_n;
            1:       return pll_rst;
            default: return sat_sys_rst_n;
        endcase
    endfunction

    // Cycles until the signal reaches lvl, or -1 if the bound expires.
    task automatic wait_for(input int id, input logic lvl, input int bound, output int n);
        n = 0;
        while (sig(id) !== lvl && n < bound) begin
            step(1);
            n++;
        end
        if (sig(id) !== lvl) n = -1;
    endtask

    task automatic high_width(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            step(1);
        end
    endtask

    initial begin
        int n;
        int tmo;
        int model;

        rst_n    = 1'b0;
        pll_lock = 1'b0;
        sat_lock = 1'b0;
        step(3);

        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst_n", int'(sys_rst_n), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_relock", int'(relock_cnt), 0);

        // 1: power-up, lock arrives 50 cycles after release
        rst_n = 1'b1;
        high_width(n);
        chk("t1_prst_width", n, 16);
        step(34);
        pll_lock = 1'b1;
        push("t1_release_lat", 259);
        wait_for(0, 1'b1, 400, n);
        pop_chk(n);
        chk("t1_locked", int'(locked), 1);
        chk("t1_pll_rst", int'(pll_rst), 0);
        chk("t1_relock", int'(relock_cnt), 0);

        // 3: a 3-cycle glitch is filtered, a 4-cycle drop is a loss
        step(5);
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        tmo = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!sys_rst_n || !locked) tmo++;
        end
        chk("t3_glitch_ignored", tmo, 0);

        pll_lock = 1'b0;
        push("t3_loss_lat", 6);
        push("t3_relock", CntEn ? 1 : 0);
        step(4);
        pll_lock = 1'b1;
        wait_for(0, 1'b0, 20, n);
        pop_chk((n < 0) ? -1 : n + 4);
        pop_chk(int'(relock_cnt));
        chk("t3_locked_low", int'(locked), 0);
        push("t3_prst_start", 1);
        wait_for(1, 1'b1, 10, n);
        pop_chk(n);
        high_width(n);
        chk("t3_prst_width", n, 16);
        push("t3_relock_release", 257);
        wait_for(0, 1'b1, 400, n);
        pop_chk(n);

        // 6: asynchronous reset in the middle of RUN
        step(5);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        #1;
        chk("t6_pll_rst", int'(pll_rst), 1);
        chk("t6_sys_rst_n", int'(sys_rst_n), 0);
        chk("t6_locked", int'(locked), 0);
        chk("t6_relock", int'(relock_cnt), 0);
        step(2);
        rst_n = 1'b1;

        // 2: no lock at all, PLL reset re-pulses with a 1016-cycle period
        mon_t2 = 1'b1;
        high_width(n);
        chk("t2_width0", n, 16);
        wait_for(1, 1'b1, 2000, n);
        chk("t2_gap0", n, 1000);
        high_width(n);
        chk("t2_width1", n, 16);
        wait_for(1, 1'b1, 2000, n);
        chk("t2_gap1", n, 1000);
        high_width(n);
        chk("t2_width2", n, 16);
        mon_t2 = 1'b0;
        step(1);
        chk("t2_no_release", t2_bad, 0);
        chk("t2_relock", int'(relock_cnt), 0);

        // 4: lock drops at STABLE cycle 100; the stable count must restart
        pll_lock = 1'b0;
        step(0);
        pll_lock = 1'b1;
        step(103);
        pll_lock = 1'b0;
        step(5);
        chk("t4_no_early_release", int'(sys_rst_n), 0);
        pll_lock = 1'b1;
        push("t4_release_lat", 259);
        wait_for(0, 1'b1, 400, n);
        pop_chk(n);
        chk("t4_locked", int'(locked), 1);

        // 5: 300 losses on the fast instance, relock count saturates
        model = 0;
        tmo   = 0;
        for (int i = 0; i < 300; i++) begin
            sat_lock = 1'b1;
            wait_for(2, 1'b1, 100, n);
            if (n < 0) tmo++;
            sat_lock = 1'b0;
            model = CntEn ? ((model < 255) ? model + 1 : 255) : 0;
            push("t5_relock", model);
            wait_for(2, 1'b0, 20, n);
            if (n < 0) tmo++;
            pop_chk(int'(sat_relock));
        end
        chk("t5_timeouts", tmo, 0);
        chk("t5_saturated", int'(sat_relock), CntEn ? 255 : 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
